// File: rtl/pid_chn_scheduler_if.sv
// pid_chn_scheduler_if: sample port from scheduler to the PID core.
// master drives valid/chn/fdb/ref, slave returns tready_i.
interface pid_chn_scheduler_if #(
   parameter int CHN_WIDTH  = 3,
   parameter int DATA_WIDTH = 16
);
   logic                  data_valid_o;
   logic [CHN_WIDTH-1:0]  data_chn_o;
   logic [DATA_WIDTH-1:0] data_fdb_o;
   logic [DATA_WIDTH-1:0] data_ref_o;
   logic                  tready_i;

   modport master (
      output data_valid_o,
      output data_chn_o,
      output data_fdb_o,
      output data_ref_o,
      input  tready_i
   );

   modport slave (
      input  data_valid_o,
      input  data_chn_o,
      input  data_fdb_o,
      input  data_ref_o,
      output tready_i
   );
endinterface

// File: rtl/pid_chn_scheduler.sv
// pid_chn_scheduler: latches per-channel feedback/reference and
// round-robins pending channels onto the PID sample port (pid).
// Ports: clk, rstn (async low), rpm_valid_i/rpm_data_i feedback,
// tr_valid_i/tr_chn_i/tr_data_i reference, stop_i, pid (master),
// pending_o, ovr_cnt_o. Option: PID_SCHED_TIMEOUT_EN (stale fdb).
module pid_chn_scheduler #(
   parameter int NUM_CHN     = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int CHN_WIDTH   = 3,
   parameter int OVR_WIDTH   = 8,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_CHN-1:0]            rpm_valid_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
   input  logic                          tr_valid_i,
   input  logic [CHN_WIDTH-1:0]          tr_chn_i,
   input  logic [DATA_WIDTH-1:0]         tr_data_i,
   input  logic [NUM_CHN-1:0]            stop_i,
   pid_chn_scheduler_if.master           pid,
   output logic [NUM_CHN-1:0]            pending_o,
   output logic [NUM_CHN*OVR_WIDTH-1:0]  ovr_cnt_o
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] fdb_q [NUM_CHN];
   logic [DATA_WIDTH-1:0] ref_q [NUM_CHN];
   logic [OVR_WIDTH-1:0]  ovr_q [NUM_CHN];
   logic [NUM_CHN-1:0]    pending_q;
   logic [NUM_CHN-1:0]    load_vec;
   logic [NUM_CHN-1:0]    tout_vec;
   logic [CHN_WIDTH-1:0]  ptr_q, ptr_nxt, sel;
   logic                  found, load, accept;
   logic                  valid_q;
   logic [CHN_WIDTH-1:0]  chn_q;
   logic [DATA_WIDTH-1:0] ofdb_q, oref_q;
   logic [DATA_WIDTH-1:0] sel_fdb, sel_ref;
   logic                  sel_stop;
   int                    j;

   // first pending channel at/after the RR pointer
   always_comb begin
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int i = 0; i < NUM_CHN; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_CHN) j = j - NUM_CHN;
         for (int k = 0; k < NUM_CHN; k++) begin
            if (k == j && pending_q[k] && !found) begin
               found = 1'b1;
               sel   = CHN_WIDTH'(k);
            end
         end
      end
   end

   always_comb begin
      sel_fdb  = '0;
      sel_ref  = '0;
      sel_stop = 1'b0;
      load_vec = '0;
      for (int k = 0; k < NUM_CHN; k++) begin
         if (sel == CHN_WIDTH'(k)) begin
            sel_fdb     = fdb_q[k];
            sel_ref     = ref_q[k];
            sel_stop    = stop_i[k];
            load_vec[k] = load;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (pid.tready_i) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ptr_nxt = (chn_q == CHN_WIDTH'(NUM_CHN-1)) ?
                    '0 : chn_q + CHN_WIDTH'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         chn_q   <= '0;
         ofdb_q  <= '0;
         oref_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            valid_q <= 1'b1;
            chn_q   <= sel;
            ofdb_q  <= sel_fdb;
            oref_q  <= sel_stop ? '0 : sel_ref;
         end else if (accept) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_nxt;
         end
      end
   end

   // a strobe in the load cycle re-arms pending with no overrun
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending_q <= '0;
         for (int k = 0; k < NUM_CHN; k++) begin
            fdb_q[k] <= '0;
            ref_q[k] <= '0;
            ovr_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_valid_i[k])
               fdb_q[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            else if (tout_vec[k])
               fdb_q[k] <= '0;
            if (tr_valid_i && tr_chn_i == CHN_WIDTH'(k))
               ref_q[k] <= tr_data_i;
            if (rpm_valid_i[k] || tout_vec[k])
               pending_q[k] <= 1'b1;
            else if (load_vec[k])
               pending_q[k] <= 1'b0;
            if (rpm_valid_i[k] && pending_q[k] && !load_vec[k] &&
                ovr_q[k] != '1)
               ovr_q[k] <= ovr_q[k] + OVR_WIDTH'(1);
         end
      end
   end

`ifdef PID_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tcnt_q [NUM_CHN];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CHN; k++) tcnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_valid_i[k] || tcnt_q[k] == TLAST)
               tcnt_q[k] <= '0;
            else
               tcnt_q[k] <= tcnt_q[k] + TW'(1);
         end
      end
   end

   for (genvar k = 0; k < NUM_CHN; k++) begin : g_tout
      assign tout_vec[k] = !rpm_valid_i[k] &&
                           tcnt_q[k] == TLAST;
   end
`else
   assign tout_vec = '0;
   // keeps TIMEOUT_CYC referenced when the timeout is built out
   if (TIMEOUT_CYC < 0) begin : g_no_tout
   end
`endif

   for (genvar k = 0; k < NUM_CHN; k++) begin : g_ovr
      assign ovr_cnt_o[k*OVR_WIDTH +: OVR_WIDTH] = ovr_q[k];
   end

   assign pending_o        = pending_q;
   assign pid.data_valid_o = valid_q;
   assign pid.data_chn_o   = chn_q;
   assign pid.data_fdb_o   = ofdb_q;
   assign pid.data_ref_o   = oref_q;

endmodule
